// File: rtl/commit_trace_buffer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// commit_trace_buffer_if : commit-side inputs and record-stream handshake
// Rev 1.0
// ---------------------------------------------------------------------------
interface commit_trace_buffer_if;
  logic        commit_valid;
  logic [15:0] c_pc;
  logic [15:0] c_inst;
  logic        c_regwrite;
  logic [2:0]  c_wreg;
  logic [15:0] c_wdata;
  logic        c_memread;
  logic        c_memwrite;
  logic [15:0] c_maddr;
  logic [15:0] c_mdata;
  logic        c_halt;
  logic        out_valid;
  logic        out_ready;
  logic [86:0] out_rec;
  logic [15:0] out_inum;

  modport master (
    output commit_valid, c_pc, c_inst, c_regwrite, c_wreg, c_wdata,
           c_memread, c_memwrite, c_maddr, c_mdata, c_halt, out_ready,
    input  out_valid, out_rec, out_inum
  );

  modport slave (
    input  commit_valid, c_pc, c_inst, c_regwrite, c_wreg, c_wdata,
           c_memread, c_memwrite, c_maddr, c_mdata, c_halt, out_ready,
    output out_valid, out_rec, out_inum
  );
endinterface
`default_nettype wire

// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// commit_trace_buffer : FIFO of committed-instruction records, RUN/DRAIN/DONE
// Rev 1.0
// ---------------------------------------------------------------------------
module commit_trace_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  commit_trace_buffer_if.slave  bus,
  output logic [31:0]           cycle_count,
  output logic [15:0]           inst_count,
  output logic                  overflow,
  output logic                  done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [86:0]   rec_mem  [DEPTH];
  logic [15:0]   inum_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [86:0]   in_rec;
  logic          valid_q;
  logic [86:0]   rec_q;
  logic [15:0]   inum_q;
  logic [86:0]   head_rec;
  logic [15:0]   head_inum;

  assign full       = (count == FULL_COUNT);
  assign pop        = valid_q && bus.out_ready;
  assign push       = (state == RUN) && bus.commit_valid && (!full || pop);
  assign drop       = (state == RUN) && bus.commit_valid && full && !pop;
  assign count_next = count + CW'(push) - CW'(pop);
  assign rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign in_rec     = {bus.c_halt, bus.c_memwrite, bus.c_memread, bus.c_regwrite,
                       bus.c_wreg, bus.c_pc, bus.c_inst, bus.c_wdata,
                       bus.c_maddr, bus.c_mdata};

  assign bus.out_valid = valid_q;
  assign bus.out_rec   = rec_q;
  assign bus.out_inum  = inum_q;

  always_ff @(posedge clk) begin
    if (push) begin
      rec_mem[wr_ptr]  <= in_rec;
      inum_mem[wr_ptr] <= inst_count;
    end
  end

  // Precompute the head seen after this edge; the incoming record bypasses
  // storage when it becomes the only entry, giving one-cycle visibility.
  always_comb begin
    head_rec  = rec_q;
    head_inum = inum_q;
    if (count_next != '0) begin
      if (push && (count == CW'(pop))) begin
        head_rec  = in_rec;
        head_inum = inst_count;
      end else begin
        head_rec  = rec_mem[rd_next];
        head_inum = inum_mem[rd_next];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      valid_q     <= 1'b0;
      rec_q       <= '0;
      inum_q      <= '0;
      cycle_count <= '0;
      inst_count  <= '0;
      overflow    <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + AW'(1);
        inst_count <= inst_count + 16'd1;
      end
      rd_ptr  <= rd_next;
      count   <= count_next;
      valid_q <= (count_next != '0);
      rec_q   <= head_rec;
      inum_q  <= head_inum;
      if (drop) begin
        overflow <= 1'b1;
      end
      case (state)
        RUN: begin
          cycle_count <= cycle_count + 32'd1;
          // A dropped halt still ends the run.
          if (bus.commit_valid && bus.c_halt) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (count_next == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 Parameter: DEPTH, 8, FIFO entries; power of two, 2..64.
REQ-002 Ports:
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- commit_valid  in  1  one instruction commits this cycle
- c_pc  in  16  PC of committing instruction
- c_inst  in  16  instruction word
- c_regwrite  in  1  register file written
- c_wreg  in  3  destination register
- c_wdata  in  16  register write data
- c_memread  in  1  load
- c_memwrite  in  1  store
- c_maddr  in  16  memory address
- c_mdata  in  16  store data
- c_halt  in  1  halt commits
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts record
- out_rec  out  87  {halt,memwrite,memread,regwrite,wreg,pc,inst,wdata,maddr,mdata}, MSB first
- out_inum  out  16  instruction number of out_rec
- cycle_count  out  32  cycles spent in RUN
- inst_count  out  16  records accepted
- overflow  out  1  sticky: a commit was dropped
- done  out  1  halt seen and FIFO drained

Function
REQ-003 The module SHALL have three states: RUN (after reset), DRAIN, DONE.
REQ-004 In RUN, a push SHALL occur when commit_valid=1 and (FIFO not full, or a pop happens in the same cycle).
REQ-005 A pushed record SHALL carry the c_* fields unmodified, with inum = inst_count before increment.
REQ-006 Each push SHALL increment inst_count by 1; inst_count wraps 0xFFFF->0x0000.
REQ-007 commit_valid=1 while full with no same-cycle pop SHALL drop the record, set overflow, and leave inst_count unchanged.
REQ-008 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-009 out_valid SHALL equal FIFO not empty; out_rec/out_inum SHALL show the head entry, registered outputs, no combinational path from the c_* inputs.
REQ-010 out_rec/out_inum SHALL hold stable while out_valid=1 and out_ready=0.
REQ-011 A record pushed at edge N SHALL be visible with out_valid=1 after edge N (one-cycle latency into an empty FIFO).
REQ-012 cycle_count SHALL increment every cycle in RUN, wrap at 2^32, and freeze on leaving RUN.
REQ-013 A push with c_halt=1 SHALL move RUN->DRAIN.
REQ-014 In DRAIN and DONE, commit_valid SHALL be ignored (no push, no count, no overflow).
REQ-015 DRAIN->DONE SHALL occur on the edge where the FIFO becomes empty; done=1 only in DONE.
REQ-016 A halt commit that is dropped by REQ-007 SHALL still move RUN->DRAIN.
REQ-017 DONE SHALL persist until reset.
REQ-018 Read and write pointers SHALL wrap modulo DEPTH; occupancy tracked 0..DEPTH exactly, without losing the full/empty distinction.

Reset
REQ-019 rst_n=0 SHALL asynchronously force: state RUN, FIFO empty, out_valid=0, out_rec=0, out_inum=0, cycle_count=0, inst_count=0, overflow=0, done=0.
REQ-020 Reset mid-DRAIN or mid-transfer SHALL discard all stored records; the first commit after reset gets inum 0.
REQ-021 Deassertion of rst_n SHALL take effect at the next rising clk edge; no push on that edge unless commit_valid=1.

Verification
REQ-022 Reset, out_ready=1, three commits (pc 0x0000,0x0002,0x0004, regwrite=1, wreg=3, wdata 0x0011) -> three records inum 0,1,2 in order, inst_count=3, overflow=0.
REQ-023 out_ready=0, DEPTH+2 back-to-back commits -> first 8 stored, overflow=1, inst_count=8; then out_ready=1 -> inums 0..7 drain, out_valid falls.
REQ-024 FIFO full, commit_valid=1 and pop in the same cycle -> push accepted, occupancy stays 8, overflow stays 0.
REQ-025 Store then halt (memwrite=1, maddr 0x0100, mdata 0xBEEF; then c_halt=1) with out_ready=0 -> DRAIN; later commits ignored; cycle_count frozen; after two pops done=1.
REQ-026 rst_n pulsed low asynchronously between clock edges while in DRAIN with 4 entries -> all outputs zero immediately; next commit yields inum 0.
REQ-027 Back-pressure: out_ready toggled every cycle over 20 commits -> every record delivered exactly once, in order, and out_rec stable while stalled.
